iu_cache_responder: RTL and testbench

//  Cache-side responder for the LEON integer unit under test: the far end of the icache/dcache ports the IU drives.
//  The UVM driver pre-loads an instruction queue (IQ) and a load-data queue (DQ).
//  The block answers IU fetches and loads from those queues, with hold/stall handshakes.
//  IU stores are captured into a store queue (SQ) for the monitor.

---
 rtl/iu_cache_responder.sv | 211 +++++++++++++++++++++
 tb/tb_iu_cache_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/iu_cache_responder.sv
// Cache-side responder for the LEON IU bench: serves fetches and loads from
// driver-filled queues and captures IU stores for the monitor.

module iu_cache_responder_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // A push into a full queue is accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    rdata    = mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

module iu_cache_responder #(
  parameter int unsigned IQ_DEPTH = 8,
  parameter int unsigned DQ_DEPTH = 8,
  parameter int unsigned SQ_DEPTH = 8,
  parameter int unsigned LOAD_LAT = 1,
  parameter logic [31:0] NOP_INST = 32'h01000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iq_push,
  input  logic [31:0] iq_wdata,
  output logic        iq_ready,
  input  logic        dq_push,
  input  logic [31:0] dq_wdata,
  output logic        dq_ready,
  input  logic        fetch_req,
  output logic [31:0] ic_data,
  input  logic        dc_req,
  input  logic        dc_read,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  output logic [31:0] dc_data,
  output logic        dc_hold_n,
  output logic        sq_valid,
  output logic [31:0] sq_addr,
  output logic [31:0] sq_data,
  input  logic        sq_pop,
  output logic        iq_underflow,
  output logic [3:0]  iq_count,
  output logic [3:0]  dq_count
);
  typedef enum logic [2:0] {IDLE, LWAIT, LRESP, STORE, STALL} state_e;

  localparam int unsigned IQ_CW = $clog2(IQ_DEPTH) + 1;
  localparam int unsigned DQ_CW = $clog2(DQ_DEPTH) + 1;
  localparam int unsigned SQ_CW = $clog2(SQ_DEPTH) + 1;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]  lat_q, lat_d;
  logic [31:0] dc_data_q, dc_data_d;
  logic        hold_n_q, hold_n_d;
  logic [31:0] ic_data_q, ic_data_d;
  logic        underflow_q, underflow_d;

  logic [31:0]      iq_head, dq_head;
  logic [63:0]      sq_head;
  logic [IQ_CW-1:0] iq_cnt;
  logic [DQ_CW-1:0] dq_cnt;
  logic [SQ_CW-1:0] sq_cnt;
  logic             iq_empty, iq_full, dq_empty, dq_full, sq_empty, sq_full;
  logic             dq_pop, sq_push;

  iu_cache_responder_fifo #(.DEPTH(IQ_DEPTH), .W(32)) u_iq (
    .clk(clk), .rst(rst), .push(iq_push), .wdata(iq_wdata), .pop(fetch_req),
    .rdata(iq_head), .count(iq_cnt), .empty(iq_empty), .full(iq_full)
  );

  iu_cache_responder_fifo #(.DEPTH(DQ_DEPTH), .W(32)) u_dq (
    .clk(clk), .rst(rst), .push(dq_push), .wdata(dq_wdata), .pop(dq_pop),
    .rdata(dq_head), .count(dq_cnt), .empty(dq_empty), .full(dq_full)
  );

  iu_cache_responder_fifo #(.DEPTH(SQ_DEPTH), .W(64)) u_sq (
    .clk(clk), .rst(rst), .push(sq_push), .wdata({addr_q, wdata_q}), .pop(sq_pop),
    .rdata(sq_head), .count(sq_cnt), .empty(sq_empty), .full(sq_full)
  );

  always_comb begin
    ic_data_d   = ic_data_q;
    underflow_d = 1'b0;
    if (fetch_req) begin
      ic_data_d   = iq_empty ? NOP_INST : iq_head;
      underflow_d = iq_empty;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lat_d     = lat_q;
    dc_data_d = dc_data_q;
    dq_pop    = 1'b0;
    sq_push   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dc_req) begin
          addr_d  = dc_addr;
          wdata_d = dc_wdata;
          lat_d   = '0;
          if (!dc_read)           state_d = STORE;
          else if (LOAD_LAT == 0) state_d = LRESP;
          else                    state_d = LWAIT;
        end
      end
      LWAIT: begin
        lat_d = lat_q + 3'd1;
        if ({29'd0, lat_q} + 32'd1 >= LOAD_LAT) state_d = LRESP;
      end
      LRESP, STALL: begin
        if (!dq_empty) begin
          dc_data_d = dq_head;
          dq_pop    = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = STALL;
        end
      end
      STORE: begin
        if (!sq_full || (sq_pop && !sq_empty)) begin
          sq_push = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The IU is released exactly on the cycles the FSM sits in IDLE.
    hold_n_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      dc_data_q   <= '0;
      hold_n_q    <= 1'b1;
      ic_data_q   <= NOP_INST;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      dc_data_q   <= dc_data_d;
      hold_n_q    <= hold_n_d;
      ic_data_q   <= ic_data_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    iq_ready     = !iq_full;
    dq_ready     = !dq_full;
    ic_data      = ic_data_q;
    dc_data      = dc_data_q;
    dc_hold_n    = hold_n_q;
    sq_valid     = !sq_empty;
    sq_addr      = sq_head[63:32];
    sq_data      = sq_head[31:0];
    iq_underflow = underflow_q;
    iq_count     = 4'(iq_cnt);
    dq_count     = 4'(dq_cnt);
  end
endmodule

// File: tb/tb_iu_cache_responder.sv
// Directed self-checking bench for iu_cache_responder (default parameters, LOAD_LAT=1).

module tb_iu_cache_responder;
  localparam logic [31:0] NOP = 32'h01000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        iq_push, dq_push, fetch_req, dc_req, dc_read, sq_pop;
  logic [31:0] iq_wdata, dq_wdata, dc_addr, dc_wdata;
  logic        iq_ready, dq_ready, dc_hold_n, sq_valid, iq_underflow;
  logic [31:0] ic_data, dc_data, sq_addr, sq_data;
  logic [3:0]  iq_count, dq_count;

  int checks = 0;
  int failures = 0;

  iu_cache_responder #(
    .IQ_DEPTH(8), .DQ_DEPTH(8), .SQ_DEPTH(8), .LOAD_LAT(1), .NOP_INST(NOP)
  ) dut (
    .clk(clk), .rst(rst),
    .iq_push(iq_push), .iq_wdata(iq_wdata), .iq_ready(iq_ready),
    .dq_push(dq_push), .dq_wdata(dq_wdata), .dq_ready(dq_ready),
    .fetch_req(fetch_req), .ic_data(ic_data),
    .dc_req(dc_req), .dc_read(dc_read), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_data(dc_data), .dc_hold_n(dc_hold_n),
    .sq_valid(sq_valid), .sq_addr(sq_addr), .sq_data(sq_data), .sq_pop(sq_pop),
    .iq_underflow(iq_underflow), .iq_count(iq_count), .dq_count(dq_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    dc_req = 1'b1; dc_read = 1'b0; dc_addr = a; dc_wdata = d;
    step();
    dc_req = 1'b0;
    step();
  endtask

  logic [31:0] exp_a [8];
  logic [31:0] exp_d [8];

  initial begin
    rst = 1'b1; iq_push = 0; dq_push = 0; fetch_req = 0; dc_req = 0; dc_read = 0; sq_pop = 0;
    iq_wdata = '0; dq_wdata = '0; dc_addr = '0; dc_wdata = '0;
    step(); step();
    rst = 1'b0;

    chk("rst_ic_data", ic_data, NOP);
    chk("rst_dc_data", dc_data, 32'h0);
    chk("rst_hold_n", 32'(dc_hold_n), 32'd1);
    chk("rst_sq_valid", 32'(sq_valid), 32'd0);
    chk("rst_underflow", 32'(iq_underflow), 32'd0);
    chk("rst_iq_ready", 32'(iq_ready), 32'd1);
    chk("rst_dq_ready", 32'(dq_ready), 32'd1);
    chk("rst_iq_count", 32'(iq_count), 32'd0);
    chk("rst_dq_count", 32'(dq_count), 32'd0);

    // Fetch A,B,C then underflow
    iq_push = 1; iq_wdata = 32'hA000_000A; step();
    iq_wdata = 32'hB000_000B; step();
    iq_wdata = 32'hC000_000C; step();
    iq_push = 0;
    chk("iq_count_3", 32'(iq_count), 32'd3);
    fetch_req = 1;
    step(); chk("fetch_A", ic_data, 32'hA000_000A); chk("iq_count_2", 32'(iq_count), 32'd2);
    chk("no_uf_A", 32'(iq_underflow), 32'd0);
    step(); chk("fetch_B", ic_data, 32'hB000_000B); chk("iq_count_1", 32'(iq_count), 32'd1);
    step(); chk("fetch_C", ic_data, 32'hC000_000C); chk("iq_count_0", 32'(iq_count), 32'd0);
    step(); chk("fetch_nop", ic_data, NOP); chk("uf_pulse", 32'(iq_underflow), 32'd1);
    fetch_req = 0;
    step(); chk("uf_clear", 32'(iq_underflow), 32'd0); chk("ic_hold", ic_data, NOP);

    // Load hit, LOAD_LAT=1
    dq_push = 1; dq_wdata = 32'hDEADBEEF; step(); dq_push = 0;
    chk("dq_count_1", 32'(dq_count), 32'd1);
    dc_req = 1; dc_read = 1; dc_addr = 32'h2000; step(); dc_req = 0;
    chk("ld_hold_c1", 32'(dc_hold_n), 32'd0);
    step(); chk("ld_hold_c2", 32'(dc_hold_n), 32'd0);
    step(); chk("ld_hold_rel", 32'(dc_hold_n), 32'd1);
    chk("ld_data", dc_data, 32'hDEADBEEF); chk("dq_count_0", 32'(dq_count), 32'd0);
    step(); chk("ld_idle_hold", 32'(dc_hold_n), 32'd1);

    // Load with DQ empty -> stall
    dc_req = 1; dc_read = 1; dc_addr = 32'h2004; step(); dc_req = 0;
    chk("stall_hold_0", 32'(dc_hold_n), 32'd0);
    for (int i = 1; i < 5; i++) begin
      step(); chk("stall_hold", 32'(dc_hold_n), 32'd0);
    end
    chk("stall_data_kept", dc_data, 32'hDEADBEEF);
    dq_push = 1; dq_wdata = 32'h13; step(); dq_push = 0;
    chk("stall_push_hold", 32'(dc_hold_n), 32'd0);
    step();
    chk("stall_data", dc_data, 32'h13); chk("stall_rel", 32'(dc_hold_n), 32'd1);
    chk("stall_dq_0", 32'(dq_count), 32'd0);

    // Fill SQ, 9th store stalls until a pop frees a slot
    for (int i = 0; i < 8; i++) begin
      do_store(32'h100 + 32'(i) * 4, 32'hA0 + 32'(i));
      chk("st_done_hold", 32'(dc_hold_n), 32'd1);
    end
    chk("sq_head0_a", sq_addr, 32'h100); chk("sq_head0_d", sq_data, 32'hA0);
    dc_req = 1; dc_read = 0; dc_addr = 32'h40; dc_wdata = 32'h55; step(); dc_req = 0;
    step(); chk("st9_stall1", 32'(dc_hold_n), 32'd0);
    step(); chk("st9_stall2", 32'(dc_hold_n), 32'd0);
    sq_pop = 1; step(); sq_pop = 0;
    chk("st9_rel", 32'(dc_hold_n), 32'd1);
    for (int i = 0; i < 7; i++) begin
      exp_a[i] = 32'h104 + 32'(i) * 4;
      exp_d[i] = 32'hA1 + 32'(i);
    end
    exp_a[7] = 32'h40; exp_d[7] = 32'h55;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(sq_valid), 32'd1);
      chk("drain_addr", sq_addr, exp_a[i]);
      chk("drain_data", sq_data, exp_d[i]);
      sq_pop = 1; step(); sq_pop = 0;
    end
    chk("drain_empty", 32'(sq_valid), 32'd0);

    // IQ full: push+fetch keeps count, push alone dropped
    iq_push = 1;
    for (int i = 0; i < 8; i++) begin
      iq_wdata = 32'h1000 + 32'(i); step();
    end
    iq_push = 0;
    chk("iq_full_count", 32'(iq_count), 32'd8); chk("iq_full_ready", 32'(iq_ready), 32'd0);
    iq_push = 1; iq_wdata = 32'h2000; fetch_req = 1; step();
    iq_push = 0; fetch_req = 0;
    chk("iq_pf_count", 32'(iq_count), 32'd8); chk("iq_pf_data", ic_data, 32'h1000);
    iq_push = 1; iq_wdata = 32'h3000; step(); iq_push = 0;
    chk("iq_drop_count", 32'(iq_count), 32'd8);
    fetch_req = 1;
    for (int i = 1; i < 8; i++) begin
      step(); chk("iq_order", ic_data, 32'h1000 + 32'(i));
    end
    step(); chk("iq_new_word", ic_data, 32'h2000);
    fetch_req = 0;
    chk("iq_empty_count", 32'(iq_count), 32'd0);

    // Reset mid-STALL
    dc_req = 1; dc_read = 1; dc_addr = 32'h3000; step(); dc_req = 0;
    step(); step();
    chk("pre_rst_stall", 32'(dc_hold_n), 32'd0);
    rst = 1; step(); rst = 0;
    chk("rst_stall_hold", 32'(dc_hold_n), 32'd1);
    chk("rst_stall_data", dc_data, 32'h0);
    dq_push = 1; dq_wdata = 32'h77; step(); dq_push = 0;
    step();
    chk("rst_no_pop", 32'(dq_count), 32'd1);
    chk("rst_no_resp", dc_data, 32'h0);
    dc_req = 1; dc_read = 1; dc_addr = 32'h3004; step(); dc_req = 0;
    step(); step();
    chk("post_rst_load", dc_data, 32'h77);

    // Reset mid-STORE (9th store stalled on full SQ)
    for (int i = 0; i < 8; i++) do_store(32'h200 + 32'(i) * 4, 32'hB0 + 32'(i));
    dc_req = 1; dc_read = 0; dc_addr = 32'h44; dc_wdata = 32'h66; step(); dc_req = 0;
    step(); chk("pre_rst_store", 32'(dc_hold_n), 32'd0);
    rst = 1; step(); rst = 0;
    chk("rst_store_hold", 32'(dc_hold_n), 32'd1);
    chk("rst_store_sq", 32'(sq_valid), 32'd0);
    step(); step();
    chk("rst_store_noent", 32'(sq_valid), 32'd0);
    chk("rst_store_iqc", 32'(iq_count), 32'd0);
    chk("rst_store_dqc", 32'(dq_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
